hub75_bcm: RTL and testbench



---
 rtl/hub75_bcm_pkg.sv | 24 ++
 rtl/hub75_bcm_timer.sv | 22 ++
 rtl/hub75_bcm.sv | 104 ++++++++++
 tb/tb_hub75_bcm.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_bcm_pkg.sv
// Shared types and constants for the HUB75 binary-code-modulation row painter.
package hub75_bcm_pkg;

  localparam int LSB_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT,
    S_BLANK,
    S_LATCH,
    S_SHOW
  } bcm_state_t;

  // On-timer must hold the longest plane: 255 << (N_PLANES-1).
  function automatic int on_w(input int n_planes);
    return LSB_W + n_planes;
  endfunction

  function automatic logic [LSB_W-1:0] lsb_len(input logic [LSB_W-1:0] cfg);
    return (cfg == '0) ? LSB_W'(1) : cfg;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Loadable down-counter that parks at zero; zero flag is decoded from the count.
module hub75_bcm_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hub75_bcm.sv
// BCM row sequencer: shifts each plane while the previous one is lit, then
// blanks, latches and shows it for lsb_len << plane cycles.
module hub75_bcm
  import hub75_bcm_pkg::*;
#(
  parameter int N_ROWS       = 32,
  parameter int N_PLANES     = 8,
  parameter int LOG_N_ROWS   = $clog2(N_ROWS),
  parameter int LOG_N_PLANES = $clog2(N_PLANES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LOG_N_ROWS-1:0]   bcm_row,
  input  logic                    bcm_go,
  output logic                    bcm_rdy,
  output logic [LOG_N_PLANES-1:0] shift_plane,
  output logic                    shift_go,
  input  logic                    shift_rdy,
  input  logic [LSB_W-1:0]        cfg_lsb_len,
  output logic [LOG_N_ROWS-1:0]   phy_addr,
  output logic                    phy_le,
  output logic                    phy_blank
);

  localparam int ON_W = on_w(N_PLANES);
  localparam logic [LOG_N_PLANES-1:0] LAST_PLANE = LOG_N_PLANES'(N_PLANES - 1);

  bcm_state_t              state;
  logic [LOG_N_ROWS-1:0]   row_q;
  logic [LOG_N_PLANES-1:0] plane;
  logic                    t_load;
  logic                    t_zero;
  logic [ON_W-1:0]         on_len;

  // Outputs are registered as the decode of the state being entered, so the
  // timer is loaded on entry to SHOW and the panel lights during SHOW itself.
  // Loading len-1 makes the zero-count cycle the last lit one, giving exactly
  // len lit cycles and only BLANK+LATCH dark between back-to-back planes.
  assign t_load = (state == S_LATCH);
  assign on_len = (ON_W'(lsb_len(cfg_lsb_len)) << plane) - ON_W'(1);

  hub75_bcm_timer #(.W(ON_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (on_len),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      row_q       <= '0;
      plane       <= '0;
      bcm_rdy     <= 1'b1;
      shift_go    <= 1'b0;
      shift_plane <= '0;
      phy_le      <= 1'b0;
      phy_blank   <= 1'b1;
      phy_addr    <= '0;
    end else begin
      if (t_zero && !t_load) phy_blank <= 1'b1;
      case (state)
        S_IDLE: if (bcm_go) begin
          row_q       <= bcm_row;
          plane       <= '0;
          shift_plane <= '0;
          shift_go    <= 1'b1;
          bcm_rdy     <= 1'b0;
          state       <= S_SHIFT;
        end
        S_SHIFT: begin
          shift_go <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: if (shift_rdy && t_zero) begin
          phy_blank <= 1'b1;
          state     <= S_BLANK;
        end
        S_BLANK: begin
          phy_le   <= 1'b1;
          phy_addr <= row_q;
          state    <= S_LATCH;
        end
        S_LATCH: begin
          phy_le    <= 1'b0;
          phy_blank <= 1'b0;
          state     <= S_SHOW;
        end
        S_SHOW: if (plane == LAST_PLANE) begin
          bcm_rdy <= 1'b1;
          state   <= S_IDLE;
        end else begin
          plane       <= plane + LOG_N_PLANES'(1);
          shift_plane <= plane + LOG_N_PLANES'(1);
          shift_go    <= 1'b1;
          state       <= S_SHIFT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_bcm.sv
// Directed bench for hub75_bcm: scoreboard of shift planes, latch addresses and lit lengths.
module tb_hub75_bcm;

  localparam int NP = 8;
  localparam int LR = 5;
  localparam int LP = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LR-1:0] bcm_row = '0;
  logic          bcm_go = 1'b0;
  logic          bcm_rdy;
  logic [LP-1:0] shift_plane;
  logic          shift_go;
  logic          shift_rdy = 1'b1;
  logic [7:0]    cfg_lsb_len = 8'd4;
  logic [LR-1:0] phy_addr;
  logic          phy_le;
  logic          phy_blank;

  always #5 clk = ~clk;

  hub75_bcm #(.N_ROWS(32), .N_PLANES(NP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bcm_row     (bcm_row),
    .bcm_go      (bcm_go),
    .bcm_rdy     (bcm_rdy),
    .shift_plane (shift_plane),
    .shift_go    (shift_go),
    .shift_rdy   (shift_rdy),
    .cfg_lsb_len (cfg_lsb_len),
    .phy_addr    (phy_addr),
    .phy_le      (phy_le),
    .phy_blank   (phy_blank)
  );

  int checks = 0, passes = 0, fails = 0;
  int q_plane[$], q_addr[$], q_lit[$];
  int lit_cnt = 0, dark_cnt = 0, max_gap = 0, n_le = 0, n_go = 0;
  bit seen_lit = 1'b0;
  int shift_dly = 10, sh_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Shifter model: drops ready on shift_go, raises it shift_dly cycles later.
  always @(negedge clk) begin
    if (!rst_n) begin
      shift_rdy = 1'b1;
      sh_cnt = 0;
    end else if (shift_go) begin
      shift_rdy = 1'b0;
      sh_cnt = shift_dly;
    end else if (sh_cnt > 0) begin
      sh_cnt--;
      if (sh_cnt == 0) shift_rdy = 1'b1;
    end
  end

  // Output monitor: pops the scoreboard as the DUT produces results.
  always @(negedge clk) begin
    if (rst_n) begin
      if (shift_go) begin
        n_go++;
        if (q_plane.size() == 0) check("unexpected shift_go", 1, 0);
        else check("shift_plane", shift_plane, q_plane.pop_front());
      end
      if (phy_le) begin
        n_le++;
        check("blank at latch", phy_blank, 1);
        if (q_addr.size() == 0) check("unexpected phy_le", 1, 0);
        else check("phy_addr", phy_addr, q_addr.pop_front());
      end
      if (!phy_blank) begin
        lit_cnt++;
        if (seen_lit && dark_cnt > max_gap) max_gap = dark_cnt;
        dark_cnt = 0;
        seen_lit = 1'b1;
      end else begin
        if (lit_cnt > 0) begin
          if (q_lit.size() == 0) check("unexpected lit period", 1, 0);
          else check("lit length", lit_cnt, q_lit.pop_front());
          lit_cnt = 0;
        end
        if (seen_lit) dark_cnt++;
      end
    end
  end

  task automatic start_test();
    n_go = 0; n_le = 0; seen_lit = 1'b0; dark_cnt = 0; max_gap = 0;
  endtask

  // Called at a negedge: queue one row's expectations and pulse bcm_go.
  task automatic paint(input int row, input int cfg);
    int len;
    len = (cfg == 0) ? 1 : cfg;
    for (int p = 0; p < NP; p++) begin
      q_plane.push_back(p);
      q_addr.push_back(row);
      q_lit.push_back(len << p);
    end
    cfg_lsb_len = 8'(cfg);
    bcm_row = LR'(row);
    bcm_go = 1'b1;
    @(negedge clk);
    bcm_go = 1'b0;
  endtask

  task automatic wait_rdy(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bcm_rdy && n < budget);
    check(tag, bcm_rdy, 1);
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while (q_lit.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, q_lit.size(), 0);
  endtask

  initial begin
    int le_seen, n;
    repeat (3) @(negedge clk);
    check("reset phy_blank", phy_blank, 1);
    check("reset phy_le", phy_le, 0);
    check("reset shift_go", shift_go, 0);
    check("reset phy_addr", phy_addr, 0);
    check("reset shift_plane", shift_plane, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset bcm_rdy", bcm_rdy, 1);

    // Nominal row: row 5, lsb 4, shifter 10 cycles
    shift_dly = 10;
    start_test();
    paint(5, 4);
    check("busy after go", bcm_rdy, 0);
    wait_rdy(6000, "t1 bcm_rdy");
    drain(3000, "t1 drain");
    check("t1 shift_go count", n_go, 8);
    check("t1 latch count", n_le, 8);

    // Back-to-back rows 0 then 1: only BLANK+LATCH dark between planes
    start_test();
    paint(0, 16);
    wait_rdy(6000, "t2 row0 bcm_rdy");
    paint(1, 16);
    wait_rdy(6000, "t2 row1 bcm_rdy");
    drain(3000, "t2 drain");
    check("t2 max dark gap", max_gap, 2);
    check("t2 latch count", n_le, 16);

    // Slow shifter, lsb 1
    shift_dly = 1000;
    start_test();
    paint(2, 1);
    wait_rdy(12000, "t3 bcm_rdy");
    drain(500, "t3 drain");
    check("t3 latch count", n_le, 8);

    // lsb 0 behaves as 1
    shift_dly = 10;
    start_test();
    paint(6, 0);
    wait_rdy(2000, "t4 bcm_rdy");
    drain(500, "t4 drain");
    check("t4 latch count", n_le, 8);

    // bcm_go while in WAIT is ignored
    shift_dly = 30;
    start_test();
    paint(3, 2);
    repeat (5) @(negedge clk);
    check("t5 busy in wait", bcm_rdy, 0);
    bcm_row = LR'(7);
    bcm_go = 1'b1;
    @(negedge clk);
    bcm_go = 1'b0;
    wait_rdy(3000, "t5 bcm_rdy");
    drain(1000, "t5 drain");
    check("t5 shift_go count", n_go, 8);
    check("t5 latch count", n_le, 8);

    // Reset during plane 3 SHOW
    shift_dly = 10;
    start_test();
    paint(9, 8);
    le_seen = 0;
    n = 0;
    while (le_seen < 4 && n < 5000) begin
      @(negedge clk);
      n++;
      if (phy_le) le_seen++;
    end
    check("t6 reached plane 3 latch", le_seen, 4);
    @(posedge clk);
    #1 rst_n = 1'b0;
    q_plane.delete(); q_addr.delete(); q_lit.delete();
    lit_cnt = 0;
    #1;
    check("t6 blank in reset", phy_blank, 1);
    check("t6 le in reset", phy_le, 0);
    check("t6 shift_go in reset", shift_go, 0);
    repeat (3) @(negedge clk);
    n_le = 0;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6 bcm_rdy after reset", bcm_rdy, 1);
    check("t6 phy_addr after reset", phy_addr, 0);
    repeat (20) @(negedge clk);
    check("t6 no latch after reset", n_le, 0);
    check("t6 still dark", phy_blank, 1);

    check("end plane queue", q_plane.size(), 0);
    check("end addr queue", q_addr.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
